// File: rtl/sertx_arbiter_pkg.sv
// Shared types and constants for the serial transmit arbiter.
package sertx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MARK  = 8'h80;
    localparam int         N_PERIPHS = 4;
    localparam int         DEF_N_REQ = N_PERIPHS;

endpackage

// File: rtl/sertx_rr_pick.sv
// Combinational round-robin pick: first set request bit at or above rr_ptr, wrapping.
module sertx_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_any
);

    int               idx;
    logic [N_REQ-1:0] req_sh;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick_onehot = '0;
        pick_id     = '0;
        pick_any    = 1'b0;
        idx         = 0;
        req_sh      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            req_sh = req >> idx;
            if (!pick_any && req_sh[0]) begin
                pick_any    = 1'b1;
                pick_onehot = N_REQ'(1) << idx;
                pick_id     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sertx_arbiter.sv
// Packet-granular round-robin arbiter in front of serial.v, with mid-packet watchdog.
// Optional SERTX_HDR_EN: send an 8'h80|grant_id header byte before each packet.
module sertx_arbiter
    import sertx_arbiter_pkg::*;
#(
    parameter int          N_REQ   = DEF_N_REQ,
    parameter int          ID_W    = 2,
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [7:0]         send_data,
    output logic               data_avail,
    input  logic               send_strobe,
    output logic [N_REQ-1:0]   grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic              old_strobe;
    logic [15:0]       wd_cnt;

    logic [N_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;

    logic [N_REQ-1:0]   valid_sh, last_sh, ack_sh;
    logic [N_REQ*8-1:0] data_sh;
    logic               sel_valid, sel_last, sel_ack;
    logic [7:0]         sel_data;
    logic               consume, wd_expire;
    logic [ID_W-1:0]    next_ptr;

    // Shifts select the owner's lane without requiring ID_W == clog2(N_REQ).
    assign valid_sh  = req_valid >> grant_id;
    assign last_sh   = req_last >> grant_id;
    assign ack_sh    = req_ack >> grant_id;
    assign data_sh   = req_data >> {grant_id, 3'b000};
    assign sel_valid = valid_sh[0];
    assign sel_last  = last_sh[0];
    assign sel_ack   = ack_sh[0];
    assign sel_data  = data_sh[7:0];

    assign consume   = old_strobe & ~send_strobe;
    assign wd_expire = (state == DATA) && !consume && !sel_valid &&
                       (wd_cnt + 16'd1 == TIMEOUT);
    assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // The byte just acked may still show valid in the following cycle; mask it out.
    sertx_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req         (req_valid & ~req_ack),
        .rr_ptr      (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_id     (pick_id),
        .pick_any    (pick_any)
    );

    always_comb begin
        state_nxt  = state;
        send_data  = '0;
        data_avail = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
`ifdef SERTX_HDR_EN
                    state_nxt = HDR;
`else
                    state_nxt = DATA;
`endif
                end
            end
            HDR: begin
                send_data  = HDR_MARK | 8'(grant_id);
                data_avail = 1'b1;
                if (consume) state_nxt = DATA;
            end
            DATA: begin
                send_data  = sel_data;
                data_avail = sel_valid & ~sel_ack;
                if ((consume && sel_last) || wd_expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            old_strobe  <= 1'b0;
            wd_cnt      <= '0;
            req_ack     <= '0;
        end else begin
            state      <= state_nxt;
            old_strobe <= send_strobe;
            req_ack    <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_onehot;
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        wd_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (consume) begin
                        req_ack <= grant;
                        wd_cnt  <= '0;
                        if (sel_last) begin
                            grant  <= '0;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!sel_valid) begin
                        wd_cnt <= wd_cnt + 16'd1;
                        if (wd_expire) begin
                            grant  <= '0;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: ;
            endcase
            // A fresh abort wins over a simultaneous clear.
            if (wd_expire)    timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sertx_arbiter.sv
// Directed self-checking bench for sertx_arbiter (N_REQ=4, TIMEOUT=16).
`timescale 1ns/1ps
module tb_sertx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] req_data;
    logic [3:0]  req_valid, req_last, req_ack, grant;
    logic [7:0]  send_data;
    logic        data_avail, send_strobe, busy, timeout_err, err_clr;
    logic [1:0]  grant_id;

    int errors = 0;
    int checks = 0;

    sertx_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16'd16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .send_data   (send_data),
        .data_avail  (data_avail),
        .send_strobe (send_strobe),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One strobe pulse; returns in the cycle after the falling edge was seen.
    task automatic pulse();
        send_strobe = 1'b1;
        tick();
        send_strobe = 1'b0;
        tick();
    endtask

    task automatic skip_hdr(input int id);
`ifdef SERTX_HDR_EN
        logic [7:0] exp_h;
        exp_h = 8'h80 | 8'(id);
        checks++;
        if (send_data !== exp_h || data_avail !== 1'b1) begin
            errors++;
            $display("FAIL hdr_byte: got %h/%b want %h/1", send_data, data_avail, exp_h);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL hdr_no_ack: got %b want 0000", req_ack);
        end
`else
        if (id < 0) $display("bad id %0d", id);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (send_data !== 8'h00 || data_avail !== 1'b0 || req_ack !== 4'b0000 ||
            grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got sd=%h da=%b ack=%b g=%b id=%0d busy=%b err=%b want all zero",
                     tag, send_data, data_avail, req_ack, grant, grant_id, busy, timeout_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_data = '0; req_valid = '0; req_last = '0;
        send_strobe = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check_reset_vals("reset_values");
        reset = 1'b0;
        tick();
        check_reset_vals("idle_no_request");
    endtask

    task automatic test_single();
        req_data[15:8] = 8'h11; req_last = 4'b0000; req_valid = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got g=%b id=%0d busy=%b want 0010/1/1", grant, grant_id, busy);
        end
        skip_hdr(1);
        checks++;
        if (send_data !== 8'h11 || data_avail !== 1'b1) begin
            errors++;
            $display("FAIL single_byte1: got %h/%b want 11/1", send_data, data_avail);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0010 || data_avail !== 1'b0) begin
            errors++;
            $display("FAIL single_ack1: got ack=%b da=%b want 0010/0", req_ack, data_avail);
        end
        req_data[15:8] = 8'h22; req_last[1] = 1'b1;
        tick();
        checks++;
        if (req_ack !== 4'b0000 || send_data !== 8'h22 || data_avail !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_byte2: got ack=%b sd=%h da=%b busy=%b want 0000/22/1/1",
                     req_ack, send_data, data_avail, busy);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0010 || busy !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_end: got ack=%b busy=%b g=%b want 0010/0/0000", req_ack, busy, grant);
        end
        req_valid = '0; req_last = '0;
        tick();
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got ack=%b busy=%b want 0000/0", req_ack, busy);
        end
    endtask

    task automatic serve(input int id, input logic [7:0] exp_d);
        logic [3:0] exp_g;
        exp_g = 4'b0001 << id;
        checks++;
        if (grant !== exp_g || busy !== 1'b1 || grant_id !== 2'(id)) begin
            errors++;
            $display("FAIL rr_grant%0d: got g=%b id=%0d busy=%b want %b", id, grant, grant_id, busy, exp_g);
        end
        skip_hdr(id);
        checks++;
        if (send_data !== exp_d) begin
            errors++;
            $display("FAIL rr_data%0d: got %h want %h", id, send_data, exp_d);
        end
        pulse();
        checks++;
        if (req_ack !== exp_g || busy !== 1'b0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL rr_end%0d: got ack=%b busy=%b g=%b want %b/0/0000", id, req_ack, busy, grant, exp_g);
        end
        req_valid[id] = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        req_data = 32'hD3_00_B1_A0; req_last = 4'b1111; req_valid = 4'b1011;
        tick();
        serve(3, 8'hD3);
        serve(0, 8'hA0);
        serve(1, 8'hB1);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got g=%b busy=%b want 0000/0", grant, busy);
        end
        req_last = '0;
    endtask

    task automatic test_stall();
        req_data[7:0] = 8'h5A; req_last = 4'b0000; req_valid = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL stall_grant: got %b want 0001", grant);
        end
        skip_hdr(0);
        pulse();
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL stall_ack: got %b want 0001", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        repeat (15) tick();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || timeout_err !== 1'b0 || data_avail !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got g=%b busy=%b err=%b da=%b want 0001/1/0/0",
                     grant, busy, timeout_err, data_avail);
        end
        err_clr = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b1 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL stall_abort: got g=%b busy=%b err=%b ack=%b want 0000/0/1/0000",
                     grant, busy, timeout_err, req_ack);
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", timeout_err);
        end
    endtask

    task automatic test_slow_host();
        int bad;
        bad = 0;
        req_data[23:16] = 8'h77; req_last = 4'b0100; req_valid = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL slow_grant: got %b want 0100", grant);
        end
        skip_hdr(2);
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (data_avail !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL slow_hold: got %0d bad cycles want 0", bad);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL slow_end: got ack=%b busy=%b want 0100/0", req_ack, busy);
        end
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_data[31:24] = 8'h31; req_last = 4'b0000; req_valid = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL rst_grant: got %b want 1000", grant);
        end
        skip_hdr(3);
        pulse();
        req_data[31:24] = 8'h32;
        tick();
        send_strobe = 1'b1;
        tick();
        send_strobe = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_vals("reset_mid_packet");
        reset = 1'b0;
        req_data[15:8] = 8'h41; req_last = 4'b0010; req_valid = 4'b1010;
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_rr_ptr: got g=%b id=%0d want 0010/1", grant, grant_id);
        end
        skip_hdr(1);
        pulse();
        req_valid = '0; req_last = '0;
        tick();
    endtask

`ifdef SERTX_HDR_EN
    task automatic test_hdr();
        req_data[23:16] = 8'h44; req_last = 4'b0100; req_valid = 4'b0100;
        tick();
        checks++;
        if (send_data !== 8'h82 || data_avail !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL hdr_first: got sd=%h da=%b g=%b want 82/1/0100", send_data, data_avail, grant);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0000 || send_data !== 8'h44) begin
            errors++;
            $display("FAIL hdr_payload: got ack=%b sd=%h want 0000/44", req_ack, send_data);
        end
        pulse();
        checks++;
        if (req_ack !== 4'b0100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hdr_end: got ack=%b busy=%b want 0100/0", req_ack, busy);
        end
        req_valid = '0; req_last = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_slow_host();
        test_reset_mid();
`ifdef SERTX_HDR_EN
        test_hdr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
